btn_reader: RTL and testbench

Input-side companion to the board LED drivers. It reads one raw push-button pin, synchronises it and debounces it. It then reports clean press/release events and classifies each press as short or long. Its outputs drive LED pattern controllers and mode selection.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_sync.sv | 38 +++
 rtl/btn_reader.sv | 161 ++++++++++++++++
 tb/tb_btn_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button reader.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned SYS_CLK_HZ    = 24_000_000;
    localparam int unsigned CYCLES_PER_MS = SYS_CLK_HZ / 1000;

    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned LONG_MS     = 1000;
    localparam int unsigned REPEAT_MS   = 250;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = DEBOUNCE_MS * CYCLES_PER_MS;
    localparam int unsigned LONG_CYCLES_DEF     = LONG_MS * CYCLES_PER_MS;
    localparam int unsigned REPEAT_CYCLES_DEF   = REPEAT_MS * CYCLES_PER_MS;

    // Counter width for a count of n states; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the button pin, reset to the inactive level,
// with the result normalised so that 1 means pressed.
module btn_sync
    import btn_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pin_raw,
    output logic pressed_c
);

    localparam logic INACTIVE = (ACTIVE_LOW != 0);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = pin_raw;
        sync_d = meta_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta_q <= INACTIVE;
            sync_q <= INACTIVE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign pressed_c = sync_q ^ INACTIVE;

endmodule

// File: rtl/btn_reader.sv
// Push-button reader: synchronise, debounce, press/release events, short/long
// classification. Define BTN_REPEAT_EN to add long-press auto-repeat.
module btn_reader
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press
);

    localparam int unsigned DEB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
`endif

    logic s_c;

    btn_state_e        state_q,    state_d;
    logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_q,     long_d;
    logic              level_q,    level_d;
    logic              press_q,    press_d;
    logic              release_q,  release_d;
    logic              short_q,    short_d;
    logic              lpulse_q,   lpulse_d;
    logic              long_fire;

    btn_sync #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .pin_raw  (btn_raw),
        .pressed_c(s_c)
    );

    // Hold timing first so a long event on the release edge suppresses short_press.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = long_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_fire  = 1'b0;

        if (state_q == PRESSED || state_q == DEB_RELEASE) begin
`ifdef BTN_REPEAT_EN
            if (!long_q && hold_cnt_q == LONG_LAST) begin
                long_fire  = 1'b1;
                long_d     = 1'b1;
                hold_cnt_d = '0;
            end else if (long_q && hold_cnt_q == REPEAT_LAST) begin
                long_fire  = 1'b1;
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
`else
            if (hold_cnt_q == LONG_LAST) begin
                long_fire = !long_q;
                long_d    = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (s_c) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!s_c) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    hold_cnt_d = '0;
                    long_d     = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (!s_c) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            DEB_RELEASE: begin
                if (s_c) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    short_d   = !(long_q || long_fire);
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        lpulse_d = long_fire;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            short_q    <= 1'b0;
            lpulse_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            short_q    <= short_d;
            lpulse_q   <= lpulse_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = lpulse_q;

endmodule

// File: tb/tb_btn_reader.sv
// Bench for btn_reader: directed scenarios plus random pin activity, checked
// each cycle against a run-length/elapsed-time reference model.
module tb_btn_reader;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam int unsigned R = 8;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic sys_clk;
    logic sys_rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;

    btn_reader #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .REPEAT_CYCLES  (R),
        .ACTIVE_LOW     (1)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pin history, accepted level, run of disagreeing samples.
    logic hist0, hist1;
    bit   lvl;
    int   run;
    int   k;
    int   t_p;
    bit   long_seen;
    bit   e_press, e_rel, e_short, e_long;

    // Per-segment observations of the DUT.
    int seg_tick;
    int n_press, n_rel, n_short, n_long, n_coinc;
    int p_at, r_at, l_at;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic raw, input logic rst);
        bit s;
        int held;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_short = 1'b0;
        e_long  = 1'b0;
        if (rst) begin
            hist0     = 1'b1;
            hist1     = 1'b1;
            lvl       = 1'b0;
            run       = 0;
            long_seen = 1'b0;
        end else begin
            s     = (hist1 == 1'b0);
            hist1 = hist0;
            hist0 = raw;
            if (lvl) begin
                held = k - t_p;
                if (held == int'(L) ||
                    (REP && held > int'(L) && ((held - int'(L)) % int'(R)) == 0)) begin
                    e_long    = 1'b1;
                    long_seen = 1'b1;
                end
            end
            if (s != lvl) run++;
            else          run = 0;
            if (run == int'(D) + 1) begin
                lvl = s;
                run = 0;
                if (s) begin
                    e_press   = 1'b1;
                    t_p       = k;
                    long_seen = 1'b0;
                end else begin
                    e_rel   = 1'b1;
                    e_short = !long_seen;
                end
            end
        end
        k++;
    endtask

    task automatic tick(input logic raw, input logic rst);
        btn_raw = raw;
        sys_rst = rst;
        @(posedge sys_clk);
        model_step(raw, rst);
        @(negedge sys_clk);
        chk("btn_level",     32'(btn_level),     32'(lvl));
        chk("press_pulse",   32'(press_pulse),   32'(e_press));
        chk("release_pulse", 32'(release_pulse), 32'(e_rel));
        chk("short_press",   32'(short_press),   32'(e_short));
        chk("long_press",    32'(long_press),    32'(e_long));
        if (press_pulse)   begin n_press++; p_at = seg_tick; end
        if (release_pulse) begin n_rel++;   r_at = seg_tick; end
        if (short_press)   n_short++;
        if (long_press)    begin n_long++; if (l_at < 0) l_at = seg_tick; end
        if (long_press && release_pulse) n_coinc++;
        seg_tick++;
    endtask

    task automatic pin(input logic raw, input int n);
        for (int i = 0; i < n; i++) tick(raw, 1'b0);
    endtask

    task automatic seg_start();
        seg_tick = 0;
        n_press  = 0;
        n_rel    = 0;
        n_short  = 0;
        n_long   = 0;
        n_coinc  = 0;
        p_at     = -1;
        r_at     = -1;
        l_at     = -1;
    endtask

    initial begin
        sys_rst   = 1'b1;
        btn_raw   = 1'b1;
        hist0     = 1'b1;
        hist1     = 1'b1;
        lvl       = 1'b0;
        run       = 0;
        k         = 0;
        t_p       = 0;
        long_seen = 1'b0;
        seg_start();

        // Reset held with the pin inactive, then released.
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
        pin(1'b1, 6);
        chk("reset_no_events", 32'(n_press + n_rel + n_short + n_long), 32'd0);

        // Clean short press.
        seg_start();
        pin(1'b0, 12);
        pin(1'b1, 10);
        chk("short_press_lat", 32'(p_at), 32'd6);
        chk("short_rel_lat",   32'(r_at), 32'd18);
        chk("short_cnt",       32'(n_short), 32'd1);
        chk("short_long_cnt",  32'(n_long),  32'd0);

        // Low glitch shorter than the debounce window.
        seg_start();
        pin(1'b0, 3);
        pin(1'b1, 10);
        chk("glitch_press_cnt", 32'(n_press), 32'd0);

        // High glitch mid-press: no release, hold time keeps accumulating.
        seg_start();
        pin(1'b0, 12);
        pin(1'b1, 2);
        pin(1'b0, 12);
        pin(1'b1, 10);
        chk("midglitch_rel_cnt", 32'(n_rel),  32'd1);
        chk("midglitch_long_at", 32'(l_at),   32'd26);
        chk("midglitch_short",   32'(n_short), 32'd0);

        // Long press.
        seg_start();
        pin(1'b0, 40);
        pin(1'b1, 10);
        chk("long_first_at", 32'(l_at - p_at), 32'd20);
        chk("long_cnt",      32'(n_long), REP ? 32'd3 : 32'd1);
        chk("long_short",    32'(n_short), 32'd0);

        // Release acceptance on the same edge as the long threshold.
        seg_start();
        pin(1'b0, 20);
        pin(1'b1, 10);
        chk("same_edge_coinc", 32'(n_coinc), 32'd1);
        chk("same_edge_short", 32'(n_short), 32'd0);

        // Extended hold: auto-repeat when enabled, none after release.
        seg_start();
        pin(1'b0, 50);
        pin(1'b1, 12);
        chk("repeat_cnt", 32'(n_long), REP ? 32'd4 : 32'd1);

        // Reset while held forces a fresh debounced press afterwards.
        seg_start();
        pin(1'b0, 12);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        pin(1'b0, 12);
        pin(1'b1, 10);
        chk("rst_mid_press_cnt", 32'(n_press), 32'd2);
        chk("rst_mid_rel_cnt",   32'(n_rel),   32'd1);

        // Random pin activity with occasional resets.
        seg_start();
        for (int i = 0; i < 60; i++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 30));
            if ($urandom_range(0, 29) == 0) begin
                tick(v, 1'b1);
                tick(v, 1'b1);
            end
            pin(v, len);
        end
        pin(1'b1, 15);
        chk("rand_settled_level", 32'(btn_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
